// File: rtl/sample_rle_packer_if.sv
// sample_rle_packer_if
//   Output-queue handshake between the capture packer and the sample RAM writer.
//   Signals:
//     out_o      queue head word (CHLS bits)
//     out_vld_o  head word valid
//     out_rdy_i  consumer accepts the head word while out_vld_o is high
//   Modports:
//     master  packer side (drives word and valid, observes ready)
//     slave   RAM writer side (observes word and valid, drives ready)
interface sample_rle_packer_if #(
    parameter int unsigned CHLS = 32
);
    logic [CHLS-1:0] out_o;
    logic            out_vld_o;
    logic            out_rdy_i;

    modport master (
        output out_o,
        output out_vld_o,
        input  out_rdy_i
    );

    modport slave (
        input  out_o,
        input  out_vld_o,
        output out_rdy_i
    );
endinterface

// File: rtl/sample_rle_packer.sv
// sample_rle_packer
//   Capture front-end of the logic analyser. On every sample strobe the enabled
//   8-bit channel groups are compacted toward the LSB. In RLE mode runs of equal
//   samples are replaced by a value word followed by a count word whose MSB is
//   set. Words are buffered in a 2-entry queue; pushes that do not fit are
//   dropped whole and latch a sticky overflow flag.
//   Ports:
//     clk_i      system clock
//     rst_i      synchronous active-high reset
//     clr_i      synchronous clear of run state, queue and overflow flag
//     chls_i     raw channel inputs
//     smp_stb_i  sample strobe, chls_i valid this cycle
//     grp_dis_i  per-group disable (1 = group dropped from the packed word)
//     rle_en_i   run-length encoding mode
//     flush_i    end of capture, emit the pending run count
//     out_if     output queue handshake (master side)
//     ovf_o      sticky: a required push was dropped
module sample_rle_packer #(
    parameter int unsigned     CHLS    = 32,
    parameter longint unsigned RLE_MAX = (64'd1 << (CHLS - 1)) - 64'd1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic [CHLS-1:0]          chls_i,
    input  logic                     smp_stb_i,
    input  logic [CHLS/8-1:0]        grp_dis_i,
    input  logic                     rle_en_i,
    input  logic                     flush_i,
    sample_rle_packer_if.master      out_if,
    output logic                     ovf_o
);

    localparam int unsigned GROUPS = CHLS / 8;
    localparam int unsigned CNT_W  = $clog2(RLE_MAX + 64'd1);
    localparam logic [CNT_W-1:0] RLE_MAX_C = CNT_W'(RLE_MAX);

    typedef enum logic {IDLE, RUN} state_t;

    // Enabled groups fill bytes 0,1,... in ascending group order.
    function automatic logic [CHLS-1:0] pack_groups(
        input logic [CHLS-1:0]   chls,
        input logic [GROUPS-1:0] dis
    );
        logic [CHLS-1:0] res;
        int unsigned     slot;
        res  = '0;
        slot = 0;
        for (int g = 0; g < GROUPS; g++) begin
            if (!dis[g]) begin
                res  = res | (CHLS'(chls[g*8 +: 8]) << (slot * 8));
                slot = slot + 1;
            end
        end
        return res;
    endfunction

    function automatic logic [CHLS-1:0] count_word(input logic [CNT_W-1:0] c);
        return {1'b1, (CHLS-1)'(c)};
    endfunction

    state_t            state, state_n;
    logic [CHLS-1:0]   prev, prev_n;
    logic [CNT_W-1:0]  count, count_n;
    logic [CHLS-1:0]   q0, q1, q0_n, q1_n;
    logic [1:0]        level, level_n;
    logic [CHLS-1:0]   packed_c, sample_c;
    logic [CHLS-1:0]   w0, w1;
    logic [1:0]        n_push;
    logic [1:0]        free;
    logic              pop, push_ok;

    assign out_if.out_o     = q0;
    assign out_if.out_vld_o = (level != 2'd0);

    // Run-length state machine: decides how many words (0..2) this cycle pushes.
    always_comb begin
        packed_c = pack_groups(chls_i, grp_dis_i);
        // MSB is reserved as the count-word flag in RLE mode.
        sample_c = {1'b0, packed_c[CHLS-2:0]};
        n_push   = 2'd0;
        w0       = '0;
        w1       = '0;
        state_n  = state;
        prev_n   = prev;
        count_n  = count;
        if (!rle_en_i) begin
            state_n = IDLE;
            if (smp_stb_i) begin
                n_push = 2'd1;
                w0     = packed_c;
            end
        end else begin
            if (smp_stb_i) begin
                if (state == IDLE) begin
                    n_push  = 2'd1;
                    w0      = sample_c;
                    prev_n  = sample_c;
                    count_n = '0;
                    state_n = RUN;
                end else if (sample_c == prev) begin
                    if (count + CNT_W'(1) == RLE_MAX_C) begin
                        n_push  = 2'd1;
                        w0      = count_word(RLE_MAX_C);
                        count_n = '0;
                    end else begin
                        count_n = count + CNT_W'(1);
                    end
                end else begin
                    if (count != '0) begin
                        n_push = 2'd2;
                        w0     = count_word(count);
                        w1     = sample_c;
                    end else begin
                        n_push = 2'd1;
                        w0     = sample_c;
                    end
                    prev_n  = sample_c;
                    count_n = '0;
                end
            end
            // Flush sees the count left after the strobe; a nonzero count
            // implies RUN, so flush in IDLE naturally does nothing.
            if (flush_i && count_n != '0 && n_push != 2'd2) begin
                if (n_push == 2'd0) begin
                    w0 = count_word(count_n);
                end else begin
                    w1 = count_word(count_n);
                end
                n_push  = n_push + 2'd1;
                count_n = '0;
            end
        end
    end

    // Queue update: a pop in this cycle frees its slot for this cycle's push.
    always_comb begin
        pop     = out_if.out_vld_o & out_if.out_rdy_i;
        free    = 2'd2 - level + {1'b0, pop};
        push_ok = (n_push <= free);
        q0_n    = q0;
        q1_n    = q1;
        level_n = level;
        if (pop) begin
            q0_n    = q1;
            level_n = level - 2'd1;
        end
        if (push_ok && n_push != 2'd0) begin
            if (n_push == 2'd2) begin
                q0_n    = w0;
                q1_n    = w1;
                level_n = 2'd2;
            end else if (level_n == 2'd0) begin
                q0_n    = w0;
                level_n = 2'd1;
            end else begin
                q1_n    = w0;
                level_n = 2'd2;
            end
        end
    end

    // Run state keeps advancing even when the push is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            state <= IDLE;
            prev  <= '0;
            count <= '0;
            q0    <= '0;
            q1    <= '0;
            level <= 2'd0;
            ovf_o <= 1'b0;
        end else begin
            state <= state_n;
            prev  <= prev_n;
            count <= count_n;
            q0    <= q0_n;
            q1    <= q1_n;
            level <= level_n;
            if (!push_ok) begin
                ovf_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sample_rle_packer.sv
module tb_sample_rle_packer;
    localparam int unsigned     CHLS    = 32;
    localparam longint unsigned RLE_MAX = 4;

    logic            clk = 1'b0;
    logic            rst, clr, stb, rle_en, flush, ovf;
    logic [CHLS-1:0] chls;
    logic [3:0]      grp_dis;

    sample_rle_packer_if #(.CHLS(CHLS)) ob ();

    sample_rle_packer #(.CHLS(CHLS), .RLE_MAX(RLE_MAX)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .clr_i     (clr),
        .chls_i    (chls),
        .smp_stb_i (stb),
        .grp_dis_i (grp_dis),
        .rle_en_i  (rle_en),
        .flush_i   (flush),
        .out_if    (ob),
        .ovf_o     (ovf)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb[$];
    logic [31:0] mon_exp;

    typedef struct {
        logic [3:0]  dis;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a word is consumed at the next posedge when vld&rdy.
    always @(negedge clk) begin
        if (rst === 1'b0 && clr === 1'b0 && ob.out_vld_o === 1'b1 && ob.out_rdy_i === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got %h expected none", ob.out_o);
            end else begin
                mon_exp = sb.pop_front();
                check("sb_word", ob.out_o, mon_exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [31:0] d);
        chls = d;
        stb  = 1'b1;
        tick();
        stb  = 1'b0;
    endtask

    task automatic flush_cyc();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{4'b0000, 32'hA5A5_1234, 32'hA5A5_1234};
        vecs[1] = '{4'b1010, 32'h4433_2211, 32'h0000_3311};
        vecs[2] = '{4'b1110, 32'h4433_2211, 32'h0000_0011};
        vecs[3] = '{4'b0101, 32'h4433_2211, 32'h0000_4422};
        vecs[4] = '{4'b1111, 32'h4433_2211, 32'h0000_0000};
        vecs[5] = '{4'b0000, 32'h8000_0001, 32'h8000_0001};
        vecs[6] = '{4'b0011, 32'hDEAD_BEEF, 32'h0000_DEAD};
        vecs[7] = '{4'b1000, 32'h1122_3344, 32'h0022_3344};

        rst = 1'b1; clr = 1'b0; stb = 1'b0; rle_en = 1'b0; flush = 1'b0;
        chls = '0; grp_dis = 4'b0000; ob.out_rdy_i = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_vld", {31'd0, ob.out_vld_o}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_out", ob.out_o, 32'd0);

        // One-cycle latency, valid for exactly one cycle with ready high.
        sb.push_back(32'hA5A5_1234);
        strobe(32'hA5A5_1234);
        @(negedge clk);
        check("lat_vld", {31'd0, ob.out_vld_o}, 32'd1);
        check("lat_out", ob.out_o, 32'hA5A5_1234);
        @(negedge clk);
        check("lat_vld_drop", {31'd0, ob.out_vld_o}, 32'd0);

        // Packing table, non-RLE.
        for (int i = 0; i < 8; i++) begin
            grp_dis = vecs[i].dis;
            sb.push_back(vecs[i].exp);
            strobe(vecs[i].din);
        end
        grp_dis = 4'b0000;
        drain();

        // Full queue plus simultaneous pop and push: no overflow.
        ob.out_rdy_i = 1'b0;
        sb.push_back(32'h11); sb.push_back(32'h22); sb.push_back(32'h33);
        strobe(32'h11);
        strobe(32'h22);
        ob.out_rdy_i = 1'b1;
        strobe(32'h33);
        @(negedge clk);
        check("poppush_ovf", {31'd0, ovf}, 32'd0);
        drain();

        // Overflow with back-pressure.
        ob.out_rdy_i = 1'b0;
        sb.push_back(32'd1); sb.push_back(32'd2);
        strobe(32'd1);
        strobe(32'd2);
        strobe(32'd3);
        @(negedge clk);
        check("ovf_set", {31'd0, ovf}, 32'd1);
        check("ovf_vld", {31'd0, ob.out_vld_o}, 32'd1);
        tick(); tick();
        @(negedge clk);
        check("ovf_hold", ob.out_o, 32'd1);
        ob.out_rdy_i = 1'b1;
        drain();
        check("ovf_sticky", {31'd0, ovf}, 32'd1);
        ob.out_rdy_i = 1'b0;
        strobe(32'h44);
        clear();
        @(negedge clk);
        check("clr_vld", {31'd0, ob.out_vld_o}, 32'd0);
        check("clr_ovf", {31'd0, ovf}, 32'd0);
        ob.out_rdy_i = 1'b1;
        repeat (3) tick();

        // RLE run then flush; a second flush emits nothing.
        rle_en = 1'b1;
        sb.push_back(32'h0000_0005); sb.push_back(32'h8000_0003); sb.push_back(32'h0000_0007);
        repeat (4) strobe(32'd5);
        strobe(32'd7);
        flush_cyc();
        drain();
        flush_cyc();
        drain();

        // Flush in the same cycle as a continuing strobe.
        clear();
        sb.push_back(32'h0000_0006); sb.push_back(32'h8000_0002); sb.push_back(32'h8000_0001);
        strobe(32'd6);
        strobe(32'd6);
        chls = 32'd6; stb = 1'b1; flush = 1'b1;
        tick();
        stb = 1'b0; flush = 1'b0;
        strobe(32'd6);
        flush_cyc();
        drain();

        // Disabled group changing does not break a run.
        clear();
        grp_dis = 4'b1000;
        sb.push_back(32'h0000_0005); sb.push_back(32'h8000_0001);
        strobe(32'hAA00_0005);
        strobe(32'hBB00_0005);
        flush_cyc();
        drain();
        grp_dis = 4'b0000;

        // Saturation at RLE_MAX=4; the MSB of the sample is the flag bit.
        clear();
        sb.push_back(32'h0000_0009); sb.push_back(32'h8000_0004); sb.push_back(32'h8000_0004);
        repeat (9) strobe(32'h8000_0009);
        drain();
        flush_cyc();
        drain();

        // Two-word push into a queue with one free slot: both dropped.
        clear();
        ob.out_rdy_i = 1'b0;
        sb.push_back(32'h0000_0005);
        repeat (3) strobe(32'd5);
        @(negedge clk);
        check("drop_pre_ovf", {31'd0, ovf}, 32'd0);
        strobe(32'd8);
        @(negedge clk);
        check("drop_ovf", {31'd0, ovf}, 32'd1);
        check("drop_head", ob.out_o, 32'h0000_0005);
        ob.out_rdy_i = 1'b1;
        drain();
        sb.push_back(32'h8000_0001);
        strobe(32'd8);
        flush_cyc();
        drain();
        check("drop_ovf_sticky", {31'd0, ovf}, 32'd1);

        // Reset mid-run.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst2_vld", {31'd0, ob.out_vld_o}, 32'd0);
        check("rst2_ovf", {31'd0, ovf}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
